pitch_gesture_filter: RTL and testbench
=======================================

# pitch_gesture_filter

Conditions the raw hi/lo pitch flags from the FFT analyzer (104 MHz domain) into clean single-cycle up/down navigation pulses on clk_100mhz. The pulses are ORed with the button rising edges into the mode menu and game controller. The block replaces the bare synchronize + edge-detect path with:
- stability qualification;
- a post-release lockout;
- optional auto-repeat while a pitch is held.

## Interface
Parameters:
- NSYNC, 3: synchronizer flop depth per input (≥2)
- STABLE_CYCLES, 2_000_000: cycles a direction must be continuously present before firing (20 ms)
- LOCKOUT_CYCLES, 25_000_000: dead time after release (250 ms)
- REPEAT_DELAY, 50_000_000: hold time before the first auto-repeat
- REPEAT_PERIOD, 20_000_000: hold time between subsequent repeats
- CNT_W, 26: shared counter width; must hold max(all cycle parameters) − 1

Ports:
- clk_100mhz  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk_100mhz
- hi_async  in  1  FFT "high pitch" flag, asynchronous
- lo_async  in  1  FFT "low pitch" flag, asynchronous
- enable  in  1  0 forces IDLE and suppresses all pulses
- repeat_en  in  1  1 enables auto-repeat while held
- up_pulse  out  1  one-cycle pulse, hi gesture
- down_pulse  out  1  one-cycle pulse, lo gesture
- hi_held  out  1  hi gesture accepted and still present
- lo_held  out  1  lo gesture accepted and still present
- state_out  out  3  FSM state, for the seven-segment debug display

## Operation
- Each input passes through its own NSYNC-flop synchronizer, giving hi_s and lo_s.
- Input code: HI if hi_s & !lo_s; LO if lo_s & !hi_s; otherwise NONE. Both-asserted is a conflict and is treated as NONE.
- The FSM uses a single counter cnt, a direction register dir (HI/LO) and a threshold register thr.
- IDLE (0): cnt = 0. On code HI/LO, latch dir = code and go to QUALIFY.
- QUALIFY (1):
  - If code != dir, go to IDLE (no pulse).
  - Else if cnt == STABLE_CYCLES−1, go to FIRE.
  - Else cnt++.
- FIRE (2): lasts exactly one cycle. Asserts up_pulse if dir = HI, down_pulse if dir = LO. Then cnt = 0 and the FSM goes to HOLD. thr is loaded with REPEAT_DELAY on entry from QUALIFY and with REPEAT_PERIOD on entry from HOLD.
- HOLD (3):
  - If code != dir, cnt = 0 and go to RELEASE.
  - Else if repeat_en and cnt == thr−1, go to FIRE.
  - Else cnt++, saturating at 2^CNT_W−1.
- RELEASE (4): cnt++ regardless of code. At cnt == LOCKOUT_CYCLES−1, go to IDLE. A direction present at exit is re-qualified from scratch.
- hi_held = (state ∈ {FIRE, HOLD}) & dir == HI. lo_held is the same with LO.
- enable low: next state IDLE and cnt = 0 from any state; outputs are 0 in that cycle onward. The synchronizers keep running.
- up_pulse and down_pulse are never high in the same cycle.

## Timing
- All outputs are decoded from registered state and dir, so they are glitch-free.
- Reset values: state IDLE (state_out = 0), cnt = 0, dir = HI, all outputs 0. Synchronizer flops clear to 0.
- Reset in any state, including mid-QUALIFY or FIRE, returns to IDLE on the next edge. No pulse is emitted in the cycle after reset.
- Latency for a clean step held steadily: NSYNC edges until hi_s is visible, +1 edge to enter QUALIFY, +STABLE_CYCLES edges to enter FIRE. up_pulse is high for the FIRE cycle only.
- A dropout shorter than STABLE_CYCLES during QUALIFY aborts the gesture. The QUALIFY count restarts only after re-entry from IDLE.
- Repeat spacing:
  - first repeat pulse occurs REPEAT_DELAY+1 cycles after the initial pulse;
  - later repeat pulses are REPEAT_PERIOD+1 cycles apart.
- Minimum spacing between gestures: a release costs LOCKOUT_CYCLES in RELEASE, and any input during lockout is ignored.

## Structure
- pitch_gesture_pkg holds the FSM state enum (IDLE=0, QUALIFY=1, FIRE=2, HOLD=3, RELEASE=4, 3 bits) and the direction typedef (HI=0, LO=1).
- Synchronizers use the existing single-bit synchronize module, one instance per input, with NSYNC passed through.
- No other sub-modules. An elaboration assertion checks that every cycle parameter is ≥1 and fits in CNT_W.

## Test plan
Use NSYNC=3, STABLE=4, LOCKOUT=8, REPEAT_DELAY=16, REPEAT_PERIOD=6 for all scenarios.
- Clean hi step: hi_async 0→1 and held, repeat_en=0 → exactly one up_pulse, 8 cycles after the first sampling edge; hi_held stays 1 until release; no down_pulse.
- Glitch rejection: lo_async high for 3 synchronized cycles, then low → no pulse; state returns to 0.
- Conflict: hi_async and lo_async both high for 50 cycles → no pulses; state_out stays 0.
- Auto-repeat: hi held for 60 cycles with repeat_en=1 → pulses at t0, t0+17, t0+24, t0+31, …
- Lockout: release lo, then reassert lo 3 cycles later → no pulse until 8 lockout cycles plus 4 qualify cycles have elapsed.
- Reset and enable: reset asserted during HOLD → all outputs 0 on the next cycle, state 0. enable=0 during QUALIFY → no pulse, state 0.

Source files
------------

// File: rtl/pitch_gesture_pkg.sv
// Shared types for the pitch gesture filter.
//   gesture_state_t : FSM state encoding, also shown on the debug display
//   gesture_dir_t   : gesture direction held by the FSM
//   cycle_param_ok  : elaboration helper, true when a cycle count is >= 1
//                     and (count - 1) fits in a counter of the given width
package pitch_gesture_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      QUALIFY = 3'd1,
      FIRE    = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } gesture_state_t;

   typedef enum logic {
      HI = 1'b0,
      LO = 1'b1
   } gesture_dir_t;

   function automatic bit cycle_param_ok(input longint p, input int w);
      return (p >= 1) && (((p - 1) >> w) == 0);
   endfunction

endpackage

// File: rtl/synchronize.sv
// Single-bit level synchronizer: NSYNC flops in series, cleared by reset.
// Ports:
//   clk_100mhz  in  destination clock
//   reset       in  synchronous active-high clear of every stage
//   async_level in  asynchronous input level
//   sync_level  out level after NSYNC stages on clk_100mhz
module synchronize #(
   parameter int NSYNC = 3
) (
   input  logic clk_100mhz,
   input  logic reset,
   input  logic async_level,
   output logic sync_level
);

   logic [NSYNC-1:0] stages;

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         stages <= '0;
      end else begin
         stages <= {stages[NSYNC-2:0], async_level};
      end
   end

   assign sync_level = stages[NSYNC-1];

endmodule

// File: rtl/pitch_gesture_filter.sv
// Turns the asynchronous hi/lo pitch flags from the FFT analyzer into clean
// single-cycle up/down navigation pulses: each direction must be stable for
// STABLE_CYCLES before it fires, a release is followed by a LOCKOUT_CYCLES
// dead time, and a held pitch can auto-repeat when repeat_en is set.
// Ports:
//   clk_100mhz  in  system clock
//   reset       in  synchronous active-high reset
//   hi_async    in  "high pitch" flag, asynchronous
//   lo_async    in  "low pitch" flag, asynchronous
//   enable      in  0 forces IDLE and silences every output
//   repeat_en   in  1 allows auto-repeat while a gesture is held
//   up_pulse    out one-cycle pulse for a hi gesture
//   down_pulse  out one-cycle pulse for a lo gesture
//   hi_held     out hi gesture accepted and still present
//   lo_held     out lo gesture accepted and still present
//   state_out   out FSM state for the debug display
module pitch_gesture_filter
   import pitch_gesture_pkg::*;
#(
   parameter int NSYNC          = 3,
   parameter int STABLE_CYCLES  = 2_000_000,
   parameter int LOCKOUT_CYCLES = 25_000_000,
   parameter int REPEAT_DELAY   = 50_000_000,
   parameter int REPEAT_PERIOD  = 20_000_000,
   parameter int CNT_W          = 26
) (
   input  logic       clk_100mhz,
   input  logic       reset,
   input  logic       hi_async,
   input  logic       lo_async,
   input  logic       enable,
   input  logic       repeat_en,
   output logic       up_pulse,
   output logic       down_pulse,
   output logic       hi_held,
   output logic       lo_held,
   output logic [2:0] state_out
);

   if (NSYNC < 2 ||
       !cycle_param_ok(longint'(STABLE_CYCLES), CNT_W) ||
       !cycle_param_ok(longint'(LOCKOUT_CYCLES), CNT_W) ||
       !cycle_param_ok(longint'(REPEAT_DELAY), CNT_W) ||
       !cycle_param_ok(longint'(REPEAT_PERIOD), CNT_W)) begin : g_bad_params
      $error("pitch_gesture_filter: NSYNC must be >= 2 and every cycle parameter >= 1 with (value-1) fitting in CNT_W bits");
   end

   // Terminal counts are stored as (cycles - 1) so they fit in CNT_W bits.
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic hi_s;
   logic lo_s;

   synchronize #(.NSYNC(NSYNC)) u_sync_hi (
      .clk_100mhz  (clk_100mhz),
      .reset       (reset),
      .async_level (hi_async),
      .sync_level  (hi_s)
   );

   synchronize #(.NSYNC(NSYNC)) u_sync_lo (
      .clk_100mhz  (clk_100mhz),
      .reset       (reset),
      .async_level (lo_async),
      .sync_level  (lo_s)
   );

   // Exactly one flag high is a valid direction; none or both is NONE.
   logic         code_valid;
   gesture_dir_t code_dir;
   logic         code_match;

   gesture_state_t   state;
   gesture_dir_t     dir;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] thr;   // current repeat threshold, minus one

   assign code_valid = hi_s ^ lo_s;
   assign code_dir   = lo_s ? LO : HI;
   assign code_match = code_valid && (code_dir == dir);

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         state <= IDLE;
         dir   <= HI;
         cnt   <= '0;
         thr   <= '0;
      end else if (!enable) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (code_valid) begin
                  dir   <= code_dir;
                  state <= QUALIFY;
               end
            end
            QUALIFY: begin
               if (!code_match) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == STABLE_LAST) begin
                  thr   <= DELAY_LAST;
                  state <= FIRE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            FIRE: begin
               cnt   <= '0;
               state <= HOLD;
            end
            HOLD: begin
               if (!code_match) begin
                  cnt   <= '0;
                  state <= RELEASE;
               end else if (repeat_en && cnt == thr) begin
                  thr   <= PERIOD_LAST;
                  state <= FIRE;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RELEASE: begin
               // Input is ignored here; whatever is present at exit
               // must qualify again from IDLE.
               if (cnt == LOCKOUT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Decoded from registered state/dir; enable gates them so a disable
   // silences the outputs in the same cycle it is applied.
   logic holding;
   assign holding    = (state == FIRE) || (state == HOLD);
   assign up_pulse   = enable && (state == FIRE) && (dir == HI);
   assign down_pulse = enable && (state == FIRE) && (dir == LO);
   assign hi_held    = enable && holding && (dir == HI);
   assign lo_held    = enable && holding && (dir == LO);
   assign state_out  = enable ? state : IDLE;

endmodule

// File: tb/tb_pitch_gesture_filter.sv
// Directed bench for pitch_gesture_filter with small cycle parameters.
// Expected pulses (direction + cycle number) are queued when the stimulus
// that causes them is driven and checked when the DUT pulses.
module tb_pitch_gesture_filter;

   localparam int NSYNC   = 3;
   localparam int STABLE  = 4;
   localparam int LOCKOUT = 8;
   localparam int RDELAY  = 16;
   localparam int RPERIOD = 6;
   localparam int CNT_W   = 8;

   // clock / reset
   logic       clk_100mhz = 1'b0;
   logic       reset;
   logic       hi_async;
   logic       lo_async;
   logic       enable;
   logic       repeat_en;
   logic       up_pulse;
   logic       down_pulse;
   logic       hi_held;
   logic       lo_held;
   logic [2:0] state_out;

   always #5 clk_100mhz = ~clk_100mhz;

   int unsigned cyc = 0;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   pitch_gesture_filter #(
      .NSYNC          (NSYNC),
      .STABLE_CYCLES  (STABLE),
      .LOCKOUT_CYCLES (LOCKOUT),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPERIOD),
      .CNT_W          (CNT_W)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .hi_async   (hi_async),
      .lo_async   (lo_async),
      .enable     (enable),
      .repeat_en  (repeat_en),
      .up_pulse   (up_pulse),
      .down_pulse (down_pulse),
      .hi_held    (hi_held),
      .lo_held    (lo_held),
      .state_out  (state_out)
   );

   // scoreboard
   int tests_run    = 0;
   int tests_failed = 0;
   logic [32:0] exp_q[$];   // {is_lo, cycle}
   logic [32:0] mon_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic expect_pulse(input logic is_lo, input int unsigned at);
      exp_q.push_back({is_lo, at});
   endtask

   // driver: advance n edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask

   always @(negedge clk_100mhz) begin
      if (up_pulse || down_pulse) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL unexpected_pulse: observed up=%0b down=%0b at cycle %0d, expected none", up_pulse, down_pulse, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pulse_dir_and_cycle", {31'd0, down_pulse, cyc}, {31'd0, mon_exp});
            check("pulse_exclusive", {63'd0, up_pulse & down_pulse}, 64'd0);
         end
      end
   end

   int unsigned c;
   int unsigned r;
   int unsigned t;

   initial begin
      reset     = 1'b1;
      hi_async  = 1'b0;
      lo_async  = 1'b0;
      enable    = 1'b1;
      repeat_en = 1'b0;
      step(3);
      check("reset_state", state_out, 0);
      check("reset_up", up_pulse, 0);
      check("reset_down", down_pulse, 0);
      check("reset_hi_held", hi_held, 0);
      check("reset_lo_held", lo_held, 0);
      reset = 1'b0;
      step(2);
      check("post_reset_idle", state_out, 0);

      // clean hi step: one up pulse NSYNC+1+STABLE edges after the drive
      hi_async = 1'b1;
      c = cyc;
      expect_pulse(1'b0, c + NSYNC + 1 + STABLE);
      step(20);
      check("clean_hi_held", hi_held, 1);
      check("clean_lo_held", lo_held, 0);
      check("clean_hold_state", state_out, 3);
      hi_async = 1'b0;
      step(NSYNC + 1);
      check("clean_release_state", state_out, 4);
      check("clean_hi_held_dropped", hi_held, 0);
      step(LOCKOUT);
      check("clean_back_idle", state_out, 0);
      step(4);
      check("clean_queue_drained", exp_q.size(), 0);

      // glitch: lo present for 3 synchronized cycles is rejected
      lo_async = 1'b1;
      step(3);
      lo_async = 1'b0;
      step(2);
      check("glitch_in_qualify", state_out, 1);
      step(5);
      check("glitch_back_idle", state_out, 0);
      check("glitch_lo_held", lo_held, 0);

      // conflict: both flags high is treated as no gesture
      hi_async = 1'b1;
      lo_async = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step(1);
         check("conflict_state", state_out, 0);
      end
      hi_async = 1'b0;
      lo_async = 1'b0;
      step(5);
      check("conflict_queue_drained", exp_q.size(), 0);

      // auto-repeat: t0, t0+RDELAY+1, then every RPERIOD+1 while held
      repeat_en = 1'b1;
      hi_async  = 1'b1;
      c = cyc;
      t = c + NSYNC + 1 + STABLE;
      expect_pulse(1'b0, t);
      t = t + RDELAY + 1;
      // a repeat fires only if hi_s is still high at its firing edge
      while (t <= c + 60 + NSYNC) begin
         expect_pulse(1'b0, t);
         t = t + RPERIOD + 1;
      end
      step(60);
      hi_async = 1'b0;
      step(NSYNC + 1 + LOCKOUT + 4);
      repeat_en = 1'b0;
      check("repeat_queue_drained", exp_q.size(), 0);
      check("repeat_back_idle", state_out, 0);

      // lockout: lo re-asserted 3 cycles after release waits out RELEASE
      lo_async = 1'b1;
      c = cyc;
      expect_pulse(1'b1, c + NSYNC + 1 + STABLE);
      step(15);
      check("lockout_lo_held", lo_held, 1);
      lo_async = 1'b0;
      r = cyc;
      step(3);
      lo_async = 1'b1;
      expect_pulse(1'b1, r + NSYNC + 1 + LOCKOUT + 1 + STABLE);
      step(3);
      check("lockout_state", state_out, 4);
      check("lockout_lo_held_low", lo_held, 0);
      step(20);
      check("lockout_requalified_held", lo_held, 1);
      lo_async = 1'b0;
      step(NSYNC + 1 + LOCKOUT + 4);
      check("lockout_queue_drained", exp_q.size(), 0);

      // reset during HOLD
      hi_async = 1'b1;
      c = cyc;
      expect_pulse(1'b0, c + NSYNC + 1 + STABLE);
      step(12);
      check("pre_reset_hold", state_out, 3);
      reset    = 1'b1;
      hi_async = 1'b0;
      step(1);
      check("reset_hold_state", state_out, 0);
      check("reset_hold_up", up_pulse, 0);
      check("reset_hold_hi_held", hi_held, 0);
      step(1);
      reset = 1'b0;
      step(NSYNC + 2);
      check("reset_hold_idle_after", state_out, 0);

      // enable low during QUALIFY
      lo_async = 1'b1;
      step(NSYNC + 2);
      check("enable_pre_qualify", state_out, 1);
      enable = 1'b0;
      #1;
      check("enable_low_same_cycle", state_out, 0);
      step(10);
      check("enable_low_state", state_out, 0);
      check("enable_low_lo_held", lo_held, 0);
      lo_async = 1'b0;
      step(NSYNC + 2);
      enable = 1'b1;
      step(3);
      check("enable_restored_idle", state_out, 0);
      check("final_queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
